// File: rtl/moore_detector_scheduler_pkg.sv
// Shared types for the Moore detector scheduler: FSM state encoding.
package moore_detector_scheduler_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

endpackage

// File: rtl/moore_detector_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  int   idx_s;
  logic hit_s;

  // Rotating priority search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    grant  = {N_REQ{1'b0}};
    winner = {ID_W{1'b0}};
    found  = 1'b0;
    idx_s  = 0;
    hit_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = ((int'(ptr) + i) >= N_REQ) ? (int'(ptr) + i - N_REQ) : (int'(ptr) + i);
      hit_s = req[idx_s] & ~found;
      grant[idx_s] = hit_s;
      winner = hit_s ? ID_W'(idx_s) : winner;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/moore_detector_scheduler.sv
// Time-shares one serial Moore detector between N_REQ requesters; counts
// detector hits per frame and reports them tagged with the requester id.
module moore_detector_scheduler
  import moore_detector_scheduler_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int ID_W      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_LEN-1:0] frame_data,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       det_reset,
  output logic                       det_i_p,
  input  logic                       det_o_p,
  output logic                       done,
  output logic [ID_W-1:0]            done_id,
  output logic [CNT_W-1:0]           hit_count
);

  localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t               state_r, state_nxt_s;
  logic [ID_W-1:0]      ptr_r, ptr_nxt_s;
  logic [FRAME_LEN-1:0] frame_r, frame_nxt_s, sel_frame_s;
  logic [BC_W-1:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [CNT_W-1:0]     hit_cnt_r, hit_cnt_nxt_s, hit_inc_s;
  logic [ID_W-1:0]      winner_r, winner_nxt_s;
  logic [N_REQ-1:0]     grant_r, grant_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 det_reset_r, det_reset_nxt_s;
  logic                 det_i_p_r, det_i_p_nxt_s;
  logic                 done_r, done_nxt_s;
  logic [ID_W-1:0]      done_id_r, done_id_nxt_s;
  logic [CNT_W-1:0]     hit_count_r, hit_count_nxt_s;

  logic [N_REQ-1:0]     arb_grant_s;
  logic [ID_W-1:0]      arb_winner_s;
  logic                 arb_found_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .grant  (arb_grant_s),
    .winner (arb_winner_s),
    .found  (arb_found_s)
  );

  // Select the winning requester's frame slice by masking with the one-hot grant.
  always_comb begin
    sel_frame_s = {FRAME_LEN{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      sel_frame_s = sel_frame_s |
                    (frame_data[k*FRAME_LEN +: FRAME_LEN] & {FRAME_LEN{arb_grant_s[k]}});
    end
  end

  assign hit_inc_s = (det_o_p && (hit_cnt_r != {CNT_W{1'b1}})) ? (hit_cnt_r + CNT_W'(1)) : hit_cnt_r;

  // Next state and next values of every register; outputs are computed one
  // cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    frame_nxt_s     = frame_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    hit_cnt_nxt_s   = hit_cnt_r;
    winner_nxt_s    = winner_r;
    grant_nxt_s     = grant_r;
    busy_nxt_s      = busy_r;
    det_reset_nxt_s = 1'b0;
    det_i_p_nxt_s   = 1'b0;
    done_nxt_s      = 1'b0;
    done_id_nxt_s   = done_id_r;
    hit_count_nxt_s = hit_count_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (arb_found_s) begin
          state_nxt_s     = ST_FLUSH;
          frame_nxt_s     = sel_frame_s;
          grant_nxt_s     = arb_grant_s;
          busy_nxt_s      = 1'b1;
          winner_nxt_s    = arb_winner_s;
          det_reset_nxt_s = 1'b1;
          ptr_nxt_s       = (arb_winner_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                               : (arb_winner_s + ID_W'(1));
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = {N_REQ{1'b0}};
          busy_nxt_s  = 1'b0;
        end
      end
      ST_FLUSH: begin
        state_nxt_s   = ST_SHIFT;
        hit_cnt_nxt_s = {CNT_W{1'b0}};
        bit_cnt_nxt_s = {BC_W{1'b0}};
        det_i_p_nxt_s = frame_r[0];
        frame_nxt_s   = {1'b0, frame_r[FRAME_LEN-1:1]};
      end
      ST_SHIFT: begin
        // The detector output during bit 0 still reflects the flush, so skip it.
        if (bit_cnt_r != {BC_W{1'b0}}) begin
          hit_cnt_nxt_s = hit_inc_s;
        end else begin
          hit_cnt_nxt_s = hit_cnt_r;
        end
        if (bit_cnt_r == BC_W'(FRAME_LEN - 1)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r + BC_W'(1);
          det_i_p_nxt_s = frame_r[0];
          frame_nxt_s   = {1'b0, frame_r[FRAME_LEN-1:1]};
        end
      end
      ST_DRAIN: begin
        state_nxt_s     = ST_REPORT;
        hit_cnt_nxt_s   = hit_inc_s;
        done_nxt_s      = 1'b1;
        done_id_nxt_s   = winner_r;
        hit_count_nxt_s = hit_inc_s;
      end
      ST_REPORT: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = {N_REQ{1'b0}};
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = {N_REQ{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r       <= {ID_W{1'b0}};
      frame_r     <= {FRAME_LEN{1'b0}};
      bit_cnt_r   <= {BC_W{1'b0}};
      hit_cnt_r   <= {CNT_W{1'b0}};
      winner_r    <= {ID_W{1'b0}};
      grant_r     <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
      det_reset_r <= 1'b0;
      det_i_p_r   <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= {ID_W{1'b0}};
      hit_count_r <= {CNT_W{1'b0}};
    end else begin
      ptr_r       <= ptr_nxt_s;
      frame_r     <= frame_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      hit_cnt_r   <= hit_cnt_nxt_s;
      winner_r    <= winner_nxt_s;
      grant_r     <= grant_nxt_s;
      busy_r      <= busy_nxt_s;
      det_reset_r <= det_reset_nxt_s;
      det_i_p_r   <= det_i_p_nxt_s;
      done_r      <= done_nxt_s;
      done_id_r   <= done_id_nxt_s;
      hit_count_r <= hit_count_nxt_s;
    end
  end

  assign grant     = grant_r;
  assign busy      = busy_r;
  assign det_reset = det_reset_r;
  assign det_i_p   = det_i_p_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign hit_count = hit_count_r;

endmodule
